// File: rtl/hvdetect.sv
// hvdetect: video timing receiver.
// Recovers pixel coordinates, measures line/frame geometry, reports lock.
module hvdetect (
  input  logic       MCLK,
  input  logic       RESET_N,
  input  logic       PCLK_EN,
  input  logic       HBLK,
  input  logic       VBLK,
  input  logic [7:0] iRGB,
  output logic [7:0] oRGB,
  output logic       DE,
  output logic [8:0] HPOS,
  output logic [8:0] VPOS,
  output logic [8:0] HTOTAL,
  output logic [8:0] HACTIVE,
  output logic [8:0] VTOTAL,
  output logic [8:0] VACTIVE,
  output logic       LOCKED
);

  logic       hb_d;
  logic       vb_d;
  logic [8:0] hcnt;
  logic [8:0] vcnt;
  logic [8:0] h_tot;
  logic [8:0] h_act;
  logic [8:0] v_act;
  logic [9:0] wdog;
  logic       frame_pend;
  logic       full_frame;
  logic       pub_ok;

  logic       h_fall;
  logic       h_rise;
  logic       v_fall;
  logic       v_rise;
  logic       f_start;
  logic       wd_exp;
  logic       blank;
  logic       same;
  logic       nonzero;
  logic [8:0] hcnt_inc;
  logic [8:0] vcnt_inc;
  logic [8:0] hcnt_nx;
  logic [8:0] vcnt_nx;
  logic [8:0] h_tot_nx;
  logic [8:0] v_act_nx;
  logic [9:0] wdog_nx;

  assign h_fall = hb_d & ~HBLK;
  assign h_rise = ~hb_d & HBLK;
  assign v_fall = vb_d & ~VBLK;
  assign v_rise = ~vb_d & VBLK;
  assign blank  = HBLK | VBLK;

  assign hcnt_inc = (&hcnt) ? hcnt : hcnt + 9'd1;
  assign vcnt_inc = (&vcnt) ? vcnt : vcnt + 9'd1;

  // A VBLK fall in the same sample arms the frame start immediately.
  assign f_start = h_fall & (frame_pend | v_fall);

  assign hcnt_nx  = h_fall ? 9'd0 : hcnt_inc;
  assign vcnt_nx  = f_start ? 9'd0
                  : h_fall ? vcnt_inc
                  : vcnt;
  assign h_tot_nx = h_fall ? hcnt_inc : h_tot;
  assign v_act_nx = v_rise ? vcnt_inc : v_act;

  assign wdog_nx = h_fall ? 10'd0
                 : (&wdog) ? wdog
                 : wdog + 10'd1;
  assign wd_exp  = ~h_fall & (wdog == 10'd1022);

  assign same = ({h_tot_nx, h_act, vcnt_inc, v_act_nx}
              == {HTOTAL, HACTIVE, VTOTAL, VACTIVE});
  assign nonzero = (|h_tot_nx) & (|h_act)
                 & (|vcnt_inc) & (|v_act_nx);

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hb_d  <= 1'b0;
      vb_d  <= 1'b0;
      hcnt  <= '0;
      vcnt  <= '0;
      h_tot <= '0;
      h_act <= '0;
      v_act <= '0;
      wdog  <= '0;
    end else if (PCLK_EN) begin
      hb_d  <= HBLK;
      vb_d  <= VBLK;
      hcnt  <= hcnt_nx;
      vcnt  <= vcnt_nx;
      h_tot <= h_tot_nx;
      v_act <= v_act_nx;
      wdog  <= wdog_nx;
      if (h_rise) begin
        h_act <= hcnt_inc;
      end
    end
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      oRGB <= '0;
      DE   <= 1'b0;
      HPOS <= '0;
      VPOS <= '0;
    end else if (PCLK_EN) begin
      oRGB <= blank ? 8'h00 : iRGB;
      DE   <= ~blank;
      HPOS <= hcnt_nx;
      VPOS <= vcnt_nx;
    end
  end

  // A frame only counts once it began at a real frame start.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_pend <= 1'b0;
      full_frame <= 1'b0;
      pub_ok     <= 1'b0;
      HTOTAL     <= '0;
      HACTIVE    <= '0;
      VTOTAL     <= '0;
      VACTIVE    <= '0;
      LOCKED     <= 1'b0;
    end else if (PCLK_EN) begin
      if (v_fall) begin
        frame_pend <= 1'b1;
      end
      if (f_start) begin
        frame_pend <= 1'b0;
        full_frame <= 1'b1;
        pub_ok     <= full_frame;
        HTOTAL     <= h_tot_nx;
        HACTIVE    <= h_act;
        VTOTAL     <= vcnt_inc;
        VACTIVE    <= v_act_nx;
        LOCKED     <= full_frame & pub_ok
                    & same & nonzero;
      end else if (wd_exp) begin
        frame_pend <= 1'b0;
        full_frame <= 1'b0;
        LOCKED     <= 1'b0;
      end
    end
  end

endmodule
